// File: rtl/vga_timing_pkg.sv
// Shared raster constants for the 640x480@60 timing generator.
// Holds the default porch/sync geometry, the derived line/frame totals
// and the width of the position counters that carry hpos/vpos.
package vga_timing_pkg;

   // Horizontal geometry in pixels.
   localparam int H_DISPLAY_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;

   // Vertical geometry in lines.
   localparam int V_DISPLAY_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;

   // 640x480@60 drives both syncs low while asserted.
   localparam logic SYNC_POL_DEF = 1'b0;

   // Position counters are 10 bits, so no axis may exceed 1024 positions.
   localparam int COUNTER_WIDTH = 10;
   localparam int COUNTER_LIMIT = 1 << COUNTER_WIDTH;

   // Total positions along one axis, visible region plus all blanking.
   function automatic int axisTotal(input int display, input int front,
                                    input int sync, input int back);
      return display + front + sync + back;
   endfunction

   localparam int H_TOTAL_DEF = axisTotal(H_DISPLAY_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
   localparam int V_TOTAL_DEF = axisTotal(V_DISPLAY_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: a wrap-around position counter plus look-ahead
// decodes of the sync window and visible region for the position the
// counter is about to take. The top level registers those decodes so
// the flags line up with the counter value on the same clock.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int TOTAL      = H_TOTAL_DEF,
   parameter int DISPLAY    = H_DISPLAY_DEF,
   parameter int SYNC_START = H_DISPLAY_DEF + H_FRONT_DEF,
   parameter int SYNC_END   = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     inc,
   output logic [COUNTER_WIDTH-1:0] count,
   output logic                     wrap,
   output logic                     nextInSync,
   output logic                     nextInDisplay
);

   // Window bounds are compared one bit wider than the counter so an
   // upper bound equal to 1024 does not truncate to zero.
   localparam int EXT_WIDTH = COUNTER_WIDTH + 1;
   localparam logic [COUNTER_WIDTH-1:0] LAST    = COUNTER_WIDTH'(TOTAL - 1);
   localparam logic [EXT_WIDTH-1:0]     SYNC_LO = EXT_WIDTH'(SYNC_START);
   localparam logic [EXT_WIDTH-1:0]     SYNC_HI = EXT_WIDTH'(SYNC_END);
   localparam logic [EXT_WIDTH-1:0]     DISP_HI = EXT_WIDTH'(DISPLAY);

   logic                     atLast;
   logic [COUNTER_WIDTH-1:0] nextCount;

   // Work out where the counter goes on this clock. Without inc the
   // position holds, so the look-ahead decodes also hold and the
   // registered flags downstream never glitch on idle cycles. The wrap
   // carry is what steps the next axis up.
   always_comb begin
      atLast    = (count == LAST);
      wrap      = inc & atLast;
      nextCount = count;
      if (inc) begin
         nextCount = atLast ? '0 : count + COUNTER_WIDTH'(1);
      end
      nextInSync    = ({1'b0, nextCount} >= SYNC_LO) && ({1'b0, nextCount} < SYNC_HI);
      nextInDisplay = ({1'b0, nextCount} < DISP_HI);
   end

   // Position register. Reset snaps straight back to the first visible
   // position regardless of where in the frame we were.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else begin
         count <= nextCount;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator for the VGA example pixel/colour logic.
// Two axis counters (horizontal stepped by the pixel enable, vertical
// stepped by the horizontal carry) produce hpos/vpos; hsync, vsync and
// display_on are registered from the counters' look-ahead so every
// output describes the same pixel. Line/frame strobes are decoded from
// the current position and qualified by the pixel enable.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_DISPLAY = H_DISPLAY_DEF,
   parameter int   H_FRONT   = H_FRONT_DEF,
   parameter int   H_SYNC    = H_SYNC_DEF,
   parameter int   H_BACK    = H_BACK_DEF,
   parameter int   V_DISPLAY = V_DISPLAY_DEF,
   parameter int   V_FRONT   = V_FRONT_DEF,
   parameter int   V_SYNC    = V_SYNC_DEF,
   parameter int   V_BACK    = V_BACK_DEF,
   parameter logic SYNC_POL  = SYNC_POL_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ce,
   output logic [COUNTER_WIDTH-1:0] hpos,
   output logic [COUNTER_WIDTH-1:0] vpos,
   output logic                     hsync,
   output logic                     vsync,
   output logic                     display_on,
   output logic                     line_start,
   output logic                     frame_start
);

   localparam int H_TOTAL = axisTotal(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
   localparam int V_TOTAL = axisTotal(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

   // A geometry that does not fit the 10-bit counters is a build error,
   // not something to discover on a monitor.
   if (H_TOTAL > COUNTER_LIMIT) begin : gHTotalTooWide
      $error("vga_timing_gen: H_TOTAL %0d exceeds counter range %0d", H_TOTAL, COUNTER_LIMIT);
   end
   if (V_TOTAL > COUNTER_LIMIT) begin : gVTotalTooWide
      $error("vga_timing_gen: V_TOTAL %0d exceeds counter range %0d", V_TOTAL, COUNTER_LIMIT);
   end

   logic hWrap;
   logic hNextInSync;
   logic hNextInDisplay;
   logic vInc;
   logic vWrap;
   logic vNextInSync;
   logic vNextInDisplay;
   logic unusedVWrap;

   vga_axis_counter #(
      .TOTAL      (H_TOTAL),
      .DISPLAY    (H_DISPLAY),
      .SYNC_START (H_DISPLAY + H_FRONT),
      .SYNC_END   (H_DISPLAY + H_FRONT + H_SYNC)
   ) hCounter (
      .clk           (clk),
      .rst           (rst),
      .inc           (ce),
      .count         (hpos),
      .wrap          (hWrap),
      .nextInSync    (hNextInSync),
      .nextInDisplay (hNextInDisplay)
   );

   // The line counter only moves on the pixel-enabled cycle that ends a
   // line, which also keeps vsync constant across a whole line.
   assign vInc = ce & hWrap;

   vga_axis_counter #(
      .TOTAL      (V_TOTAL),
      .DISPLAY    (V_DISPLAY),
      .SYNC_START (V_DISPLAY + V_FRONT),
      .SYNC_END   (V_DISPLAY + V_FRONT + V_SYNC)
   ) vCounter (
      .clk           (clk),
      .rst           (rst),
      .inc           (vInc),
      .count         (vpos),
      .wrap          (vWrap),
      .nextInSync    (vNextInSync),
      .nextInDisplay (vNextInDisplay)
   );

   // The frame carry has no consumer at this level.
   assign unusedVWrap = vWrap;

   // Register the sync and visible flags from the positions the counters
   // are moving to, so they land on the same edge as hpos/vpos and no
   // counter decode reaches the pins combinationally. Reset shows the
   // first visible pixel: syncs idle, display on.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hsync      <= ~SYNC_POL;
         vsync      <= ~SYNC_POL;
         display_on <= 1'b1;
      end else begin
         hsync      <= hNextInSync ? SYNC_POL : ~SYNC_POL;
         vsync      <= vNextInSync ? SYNC_POL : ~SYNC_POL;
         display_on <= hNextInDisplay & vNextInDisplay;
      end
   end

   // Strobes mark the pixel-enabled cycle that sits on column 0 (and
   // line 0 for the frame strobe). They are held low during reset even
   // though the counters already read zero there.
   always_comb begin
      line_start  = ce & ~rst & (hpos == '0);
      frame_start = ce & ~rst & (hpos == '0) & (vpos == '0);
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. A full 640x480 instance covers
// reset and line-level timing; two reduced-geometry instances (15x13,
// active-low and active-high syncs) cover whole-frame behaviour in a
// few hundred clocks.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst;
   logic ce;

   logic [9:0] fHpos, fVpos, sHpos, sVpos, pHpos, pVpos;
   logic fHsync, fVsync, fDisplay, fLine, fFrame;
   logic sHsync, sVsync, sDisplay, sLine, sFrame;
   logic pHsync, pVsync, pDisplay, pLine, pFrame;

   int testsRun    = 0;
   int testsFailed = 0;

   // Reduced geometry: H 8+2+3+2 = 15 (hsync 10..12), V 6+2+2+3 = 13 (vsync 8..9).
   localparam int SH_TOTAL = 15;
   localparam int SV_TOTAL = 13;
   localparam int S_FRAME  = SH_TOTAL * SV_TOTAL;

   always #5 clk = ~clk;

   vga_timing_gen dutFull (
      .clk(clk), .rst(rst), .ce(ce),
      .hpos(fHpos), .vpos(fVpos), .hsync(fHsync), .vsync(fVsync),
      .display_on(fDisplay), .line_start(fLine), .frame_start(fFrame)
   );

   vga_timing_gen #(
      .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_POL(1'b0)
   ) dutSmall (
      .clk(clk), .rst(rst), .ce(ce),
      .hpos(sHpos), .vpos(sVpos), .hsync(sHsync), .vsync(sVsync),
      .display_on(sDisplay), .line_start(sLine), .frame_start(sFrame)
   );

   vga_timing_gen #(
      .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_POL(1'b1)
   ) dutSmallPos (
      .clk(clk), .rst(rst), .ce(ce),
      .hpos(pHpos), .vpos(pVpos), .hsync(pHsync), .vsync(pVsync),
      .display_on(pDisplay), .line_start(pLine), .frame_start(pFrame)
   );

   // Sync level for a position given its asserted window and polarity.
   function automatic logic expSync(input int pos, input int lo, input int hi, input logic pol);
      return (pos >= lo && pos < hi) ? pol : ~pol;
   endfunction

   // Pulse reset for one edge with the pixel enable off; returns just
   // after an edge with every counter at zero.
   task automatic applyReset();
      rst = 1'b1;
      ce  = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Reset values, strobe suppression during reset, and the first pixel.
   task automatic test_reset();
      rst = 1'b1;
      ce  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      testsRun++;
      if ({fHpos, fVpos} !== 20'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_counters: hpos=%0d vpos=%0d, required 0 0", fHpos, fVpos);
      end
      testsRun++;
      if ({fHsync, fVsync, fDisplay} !== 3'b111) begin
         testsFailed++;
         $display("[TB] FAIL reset_flags: hsync/vsync/display=%b, required 111", {fHsync, fVsync, fDisplay});
      end
      testsRun++;
      if ({fLine, fFrame, sLine, sFrame} !== 4'b0000) begin
         testsFailed++;
         $display("[TB] FAIL reset_strobes: %b, required 0000", {fLine, fFrame, sLine, sFrame});
      end
      testsRun++;
      if ({pHsync, pVsync, pDisplay} !== 3'b001) begin
         testsFailed++;
         $display("[TB] FAIL reset_pos_polarity: hsync/vsync/display=%b, required 001", {pHsync, pVsync, pDisplay});
      end
      rst = 1'b0;
      ce  = 1'b1;
      #1;
      testsRun++;
      if ({fLine, fFrame} !== 2'b11) begin
         testsFailed++;
         $display("[TB] FAIL first_ce_strobes: line/frame=%b, required 11", {fLine, fFrame});
      end
      @(posedge clk);
      #1;
      testsRun++;
      if ({fHpos, fLine, fFrame} !== {10'd1, 2'b00}) begin
         testsFailed++;
         $display("[TB] FAIL after_first_pixel: hpos=%0d line/frame=%b, required 1 00", fHpos, {fLine, fFrame});
      end
   endtask

   // Continuous ce on the full geometry: two lines and a bit.
   task automatic test_line();
      int h, v;
      int hBad = 0, vBad = 0, syncBad = 0, dispBad = 0, strobeBad = 0;
      int hLowCount = 0, dispCount = 0, lineCount = 0, frameCount = 0;
      int hLowFirst = -1, hLowLast = -1;
      string hMsg = "", vMsg = "", syncMsg = "", dispMsg = "", strobeMsg = "";
      applyReset();
      for (int i = 0; i < 1701; i++) begin
         ce = 1'b1;
         #1;
         h = i % 800;
         v = i / 800;
         if (fHpos !== 10'(h)) begin
            if (hBad == 0) hMsg = $sformatf("cycle %0d actual %0d required %0d", i, fHpos, h);
            hBad++;
         end
         if (fVpos !== 10'(v)) begin
            if (vBad == 0) vMsg = $sformatf("cycle %0d actual %0d required %0d", i, fVpos, v);
            vBad++;
         end
         if ({fHsync, fVsync} !== {expSync(h, 656, 752, 1'b0), 1'b1}) begin
            if (syncBad == 0) syncMsg = $sformatf("hpos %0d actual %b required %b", h, {fHsync, fVsync}, {expSync(h, 656, 752, 1'b0), 1'b1});
            syncBad++;
         end
         if (fDisplay !== (h < 640)) begin
            if (dispBad == 0) dispMsg = $sformatf("hpos %0d actual %b required %b", h, fDisplay, (h < 640));
            dispBad++;
         end
         if ({fLine, fFrame} !== {(h == 0), (h == 0 && v == 0)}) begin
            if (strobeBad == 0) strobeMsg = $sformatf("cycle %0d actual %b required %b", i, {fLine, fFrame}, {(h == 0), (h == 0 && v == 0)});
            strobeBad++;
         end
         if (v == 0 && fHsync === 1'b0) begin
            if (hLowFirst < 0) hLowFirst = h;
            hLowLast = h;
            hLowCount++;
         end
         if (v == 0 && fDisplay === 1'b1) dispCount++;
         if (fLine === 1'b1) lineCount++;
         if (fFrame === 1'b1) frameCount++;
         @(posedge clk);
         #1;
      end
      testsRun++;
      if (hBad !== 0) begin testsFailed++; $display("[TB] FAIL line_hpos: %0d bad, first %s", hBad, hMsg); end
      testsRun++;
      if (vBad !== 0) begin testsFailed++; $display("[TB] FAIL line_vpos: %0d bad, first %s", vBad, vMsg); end
      testsRun++;
      if (syncBad !== 0) begin testsFailed++; $display("[TB] FAIL line_sync: %0d bad, first %s", syncBad, syncMsg); end
      testsRun++;
      if (dispBad !== 0) begin testsFailed++; $display("[TB] FAIL line_display: %0d bad, first %s", dispBad, dispMsg); end
      testsRun++;
      if (strobeBad !== 0) begin testsFailed++; $display("[TB] FAIL line_strobes: %0d bad, first %s", strobeBad, strobeMsg); end
      testsRun++;
      if (hLowCount !== 96 || hLowFirst !== 656 || hLowLast !== 751) begin
         testsFailed++;
         $display("[TB] FAIL hsync_window: low %0d clocks %0d..%0d, required 96 clocks 656..751", hLowCount, hLowFirst, hLowLast);
      end
      testsRun++;
      if (dispCount !== 640) begin testsFailed++; $display("[TB] FAIL display_count: %0d, required 640", dispCount); end
      testsRun++;
      if (lineCount !== 3 || frameCount !== 1) begin
         testsFailed++;
         $display("[TB] FAIL line_strobe_count: line %0d frame %0d, required 3 1", lineCount, frameCount);
      end
   endtask

   // Two full reduced frames with both sync polarities.
   task automatic test_frame();
      int h, v;
      int posBad = 0, syncBad = 0, dispBad = 0, polBad = 0, strobeBad = 0;
      int vLow = 0, vLowFirst = -1, frames = 0, lastFrameAt = -1, frameGap = 0;
      string posMsg = "", syncMsg = "", dispMsg = "", polMsg = "", strobeMsg = "";
      applyReset();
      for (int i = 0; i <= 2 * S_FRAME; i++) begin
         ce = 1'b1;
         #1;
         h = i % SH_TOTAL;
         v = (i / SH_TOTAL) % SV_TOTAL;
         if ({sHpos, sVpos} !== {10'(h), 10'(v)}) begin
            if (posBad == 0) posMsg = $sformatf("cycle %0d actual %0d,%0d required %0d,%0d", i, sHpos, sVpos, h, v);
            posBad++;
         end
         if ({sHsync, sVsync} !== {expSync(h, 10, 13, 1'b0), expSync(v, 8, 10, 1'b0)}) begin
            if (syncBad == 0) syncMsg = $sformatf("pos %0d,%0d actual %b required %b", h, v, {sHsync, sVsync}, {expSync(h, 10, 13, 1'b0), expSync(v, 8, 10, 1'b0)});
            syncBad++;
         end
         if (sDisplay !== (h < 8 && v < 6)) begin
            if (dispBad == 0) dispMsg = $sformatf("pos %0d,%0d actual %b required %b", h, v, sDisplay, (h < 8 && v < 6));
            dispBad++;
         end
         if ({pHpos, pVpos, pHsync, pVsync, pDisplay, pLine, pFrame} !==
             {10'(h), 10'(v), expSync(h, 10, 13, 1'b1), expSync(v, 8, 10, 1'b1), (h < 8 && v < 6), (h == 0), (h == 0 && v == 0)}) begin
            if (polBad == 0) polMsg = $sformatf("pos %0d,%0d actual sync %b required %b", h, v, {pHsync, pVsync}, {expSync(h, 10, 13, 1'b1), expSync(v, 8, 10, 1'b1)});
            polBad++;
         end
         if ({sLine, sFrame} !== {(h == 0), (h == 0 && v == 0)}) begin
            if (strobeBad == 0) strobeMsg = $sformatf("cycle %0d actual %b required %b", i, {sLine, sFrame}, {(h == 0), (h == 0 && v == 0)});
            strobeBad++;
         end
         if (i < S_FRAME && sVsync === 1'b0) begin
            if (vLowFirst < 0) vLowFirst = i;
            vLow++;
         end
         if (sFrame === 1'b1) begin
            if (lastFrameAt >= 0) frameGap = i - lastFrameAt;
            lastFrameAt = i;
            frames++;
         end
         @(posedge clk);
         #1;
      end
      testsRun++;
      if (posBad !== 0) begin testsFailed++; $display("[TB] FAIL frame_position: %0d bad, first %s", posBad, posMsg); end
      testsRun++;
      if (syncBad !== 0) begin testsFailed++; $display("[TB] FAIL frame_sync: %0d bad, first %s", syncBad, syncMsg); end
      testsRun++;
      if (dispBad !== 0) begin testsFailed++; $display("[TB] FAIL frame_display: %0d bad, first %s", dispBad, dispMsg); end
      testsRun++;
      if (polBad !== 0) begin testsFailed++; $display("[TB] FAIL frame_pos_polarity: %0d bad, first %s", polBad, polMsg); end
      testsRun++;
      if (strobeBad !== 0) begin testsFailed++; $display("[TB] FAIL frame_strobes: %0d bad, first %s", strobeBad, strobeMsg); end
      testsRun++;
      if (vLow !== 30 || vLowFirst !== 120) begin
         testsFailed++;
         $display("[TB] FAIL vsync_window: low %0d clocks from cycle %0d, required 30 from 120", vLow, vLowFirst);
      end
      testsRun++;
      if (frames !== 3 || frameGap !== S_FRAME) begin
         testsFailed++;
         $display("[TB] FAIL frame_period: %0d pulses gap %0d, required 3 gap %0d", frames, frameGap, S_FRAME);
      end
   endtask

   // ce pattern 1,0,0,1: counters step only on enabled cycles.
   task automatic test_ce_pattern();
      int eh = 0, ev = 0, ef = 0, ceCount = 0, frames = 0, frameCe = -1;
      int posBad = 0, idleBad = 0, strobeBad = 0;
      logic c;
      string posMsg = "", idleMsg = "", strobeMsg = "";
      applyReset();
      for (int i = 0; i < 1000 && ceCount < S_FRAME + 1; i++) begin
         c  = (i % 4 == 0) || (i % 4 == 3);
         ce = c;
         #1;
         if ({sHpos, sVpos, fHpos} !== {10'(eh), 10'(ev), 10'(ef)}) begin
            if (posBad == 0) posMsg = $sformatf("cycle %0d actual %0d,%0d,%0d required %0d,%0d,%0d", i, sHpos, sVpos, fHpos, eh, ev, ef);
            posBad++;
         end
         if (!c && {sLine, sFrame, fLine, fFrame} !== 4'b0000) begin
            if (idleBad == 0) idleMsg = $sformatf("cycle %0d actual %b required 0000", i, {sLine, sFrame, fLine, fFrame});
            idleBad++;
         end
         if (c && {sLine, sFrame} !== {(eh == 0), (eh == 0 && ev == 0)}) begin
            if (strobeBad == 0) strobeMsg = $sformatf("cycle %0d actual %b required %b", i, {sLine, sFrame}, {(eh == 0), (eh == 0 && ev == 0)});
            strobeBad++;
         end
         if (c && sFrame === 1'b1) begin
            frames++;
            frameCe = ceCount;
         end
         @(posedge clk);
         #1;
         if (c) begin
            ceCount++;
            ef = (ef + 1) % 800;
            if (eh == SH_TOTAL - 1) begin
               eh = 0;
               ev = (ev == SV_TOTAL - 1) ? 0 : ev + 1;
            end else begin
               eh = eh + 1;
            end
         end
      end
      testsRun++;
      if (posBad !== 0) begin testsFailed++; $display("[TB] FAIL ce_position: %0d bad, first %s", posBad, posMsg); end
      testsRun++;
      if (idleBad !== 0) begin testsFailed++; $display("[TB] FAIL ce_idle_strobes: %0d bad, first %s", idleBad, idleMsg); end
      testsRun++;
      if (strobeBad !== 0) begin testsFailed++; $display("[TB] FAIL ce_strobes: %0d bad, first %s", strobeBad, strobeMsg); end
      testsRun++;
      if (ceCount !== S_FRAME + 1 || frames !== 2 || frameCe !== S_FRAME) begin
         testsFailed++;
         $display("[TB] FAIL ce_frame_length: ce %0d frames %0d last at ce %0d, required %0d 2 %0d", ceCount, frames, frameCe, S_FRAME + 1, S_FRAME);
      end
   endtask

   // Reset asserted inside both sync pulses, then a clean restart.
   task automatic test_reset_mid_frame();
      int h;
      int extBad = 0;
      string extMsg = "";
      applyReset();
      ce = 1'b1;
      repeat (146) @(posedge clk);
      #1;
      testsRun++;
      if ({sHpos, sVpos, sHsync, sVsync} !== {10'd11, 10'd9, 2'b00}) begin
         testsFailed++;
         $display("[TB] FAIL mid_frame_setup: pos %0d,%0d sync %b, required 11,9 00", sHpos, sVpos, {sHsync, sVsync});
      end
      #3;
      rst = 1'b1;
      #1;
      testsRun++;
      if ({sHpos, sVpos, fHpos, fVpos} !== 40'd0) begin
         testsFailed++;
         $display("[TB] FAIL async_reset_counters: %0d,%0d %0d,%0d, required all 0", sHpos, sVpos, fHpos, fVpos);
      end
      testsRun++;
      if ({sHsync, sVsync, sDisplay, pHsync, pVsync, sFrame} !== 6'b111000) begin
         testsFailed++;
         $display("[TB] FAIL async_reset_flags: %b, required 111000", {sHsync, sVsync, sDisplay, pHsync, pVsync, sFrame});
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 2 * SH_TOTAL; i++) begin
         ce = 1'b1;
         #1;
         if (i == 0) begin
            testsRun++;
            if ({sFrame, sLine} !== 2'b11) begin
               testsFailed++;
               $display("[TB] FAIL restart_frame_start: %b, required 11", {sFrame, sLine});
            end
         end
         h = i % SH_TOTAL;
         if ({sHsync, sVsync} !== {expSync(h, 10, 13, 1'b0), 1'b1}) begin
            if (extBad == 0) extMsg = $sformatf("cycle %0d actual %b required %b", i, {sHsync, sVsync}, {expSync(h, 10, 13, 1'b0), 1'b1});
            extBad++;
         end
         @(posedge clk);
         #1;
      end
      testsRun++;
      if (extBad !== 0) begin testsFailed++; $display("[TB] FAIL restart_sync: %0d bad, first %s", extBad, extMsg); end
   endtask

   // Run the scenarios in order, then print the summary.
   initial begin
      rst = 1'b1;
      ce  = 1'b0;
      test_reset();
      test_line();
      test_frame();
      test_ce_pattern();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   // Time limit so a stuck run still terminates.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] time limit");
   end

endmodule
